// File: rtl/mc_control.sv
// Multicycle RV32I control FSM driving the ALU, regfile, PC and memory port strobes.
// Optional retired-instruction counter enabled by defining MC_CONTROL_PERF_EN.
module mc_control #(
    parameter int STALL_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [2:0]  flags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam int CW = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;

    state_t        state, state_next;
    logic [CW-1:0] stall_cnt;
    logic          stall_hit;
    logic          stalling;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          f7b5;
    logic          is_load, is_store, legal;
    logic          flag_eq, flag_lt, flag_ltu;
    logic          br_taken;
    logic [3:0]    arith_op;
    logic          unused_bits;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign f7b5     = instr[30];
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign {flag_eq, flag_lt, flag_ltu} = flags;
    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign legal = (opcode == OPC_OP)    || (opcode == OPC_OPIMM)  || (opcode == OPC_LUI)   ||
                   (opcode == OPC_AUIPC) || (opcode == OPC_LOAD)   || (opcode == OPC_STORE) ||
                   (opcode == OPC_BRANCH)|| (opcode == OPC_JAL)    || (opcode == OPC_JALR);

    // The cycle that would bring the stall count up to STALL_MAX is the last one allowed.
    assign stall_hit = (STALL_MAX != 0) && (stall_cnt == CW'(STALL_MAX - 1));
    assign stalling  = ((state == FETCH) || (state == MEM)) && !mem_ready && (state_next == state);
    assign fault     = (state == FAULT);

    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000:  arith_op = (opcode == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = flag_eq;
            3'b001:  br_taken = !flag_eq;
            3'b100:  br_taken = flag_lt;
            3'b101:  br_taken = !flag_lt;
            3'b110:  br_taken = flag_ltu;
            3'b111:  br_taken = !flag_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            stall_cnt <= '0;
        end else begin
            state     <= state_next;
            stall_cnt <= stalling ? stall_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        alu_ctrl   = ALU_ADD;
        alu_a_sel  = 2'd0;
        alu_b_sel  = 2'd0;
        rf_we      = 1'b0;
        wb_sel     = 2'd0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    alu_a_sel  = 2'd1;
                    alu_b_sel  = 2'd2;
                    state_next = DECODE;
                end else if (stall_hit) begin
                    state_next = FAULT;
                end
            end
            DECODE: begin
                alu_a_sel  = 2'd2;
                alu_b_sel  = 2'd1;
                state_next = legal ? EXEC : FAULT;
            end
            EXEC: begin
                case (opcode)
                    OPC_OP: begin
                        alu_ctrl   = arith_op;
                        state_next = WB;
                    end
                    OPC_OPIMM: begin
                        alu_b_sel  = 2'd1;
                        alu_ctrl   = arith_op;
                        state_next = WB;
                    end
                    OPC_LUI: begin
                        alu_b_sel  = 2'd1;
                        alu_ctrl   = ALU_PASSB;
                        state_next = WB;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel  = 2'd2;
                        alu_b_sel  = 2'd1;
                        state_next = WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel  = 2'd1;
                        state_next = MEM;
                    end
                    OPC_BRANCH: begin
                        alu_ctrl   = ALU_SUB;
                        pc_we      = br_taken;
                        pc_src     = br_taken ? 2'd1 : 2'd0;
                        state_next = FETCH;
                    end
                    OPC_JAL: begin
                        pc_we      = 1'b1;
                        pc_src     = 2'd1;
                        rf_we      = 1'b1;
                        wb_sel     = 2'd2;
                        state_next = FETCH;
                    end
                    OPC_JALR: begin
                        alu_b_sel  = 2'd1;
                        pc_we      = 1'b1;
                        pc_src     = 2'd2;
                        rf_we      = 1'b1;
                        wb_sel     = 2'd2;
                        state_next = FETCH;
                    end
                    default: state_next = FAULT;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (mem_ready) begin
                    state_next = is_store ? FETCH : WB;
                end else if (stall_hit) begin
                    state_next = FAULT;
                end
            end
            WB: begin
                rf_we      = 1'b1;
                wb_sel     = is_load ? 2'd1 : 2'd0;
                state_next = FETCH;
            end
            default: state_next = FAULT;
        endcase

        // Strobes stay quiet for the whole reset cycle, even mid-transaction.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
        end
    end

`ifdef MC_CONTROL_PERF_EN
    logic        retire;
    logic [31:0] instret_q;

    assign retire = ((state == EXEC) || (state == MEM) || (state == WB)) && (state_next == FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control: walks instruction classes through the FSM and checks strobes.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [2:0]  flags;
    logic        mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_we, pc_we, rf_we, fault;
    logic [1:0]  pc_src, alu_a_sel, alu_b_sel, wb_sel;
    logic [3:0]  alu_ctrl;
    logic [31:0] instret;
    logic [18:0] obsCtl;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4020D193;
    localparam logic [31:0] I_ADDIN = 32'h40008193;
    localparam logic [31:0] I_LUI   = 32'h123451B7;
    localparam logic [31:0] I_BEQ   = 32'h00208063;
    localparam logic [31:0] I_BNE   = 32'h00209063;
    localparam logic [31:0] I_BGEU  = 32'h0020F063;
    localparam logic [31:0] I_LW    = 32'h0000A183;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_JAL   = 32'h000000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_ILL   = 32'h0000007F;

    always #5 clk = ~clk;

    mc_control #(.STALL_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .flags     (flags),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_ctrl  (alu_ctrl),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .fault     (fault),
        .instret   (instret)
    );

    assign obsCtl = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_ctrl,
                     alu_a_sel, alu_b_sel, rf_we, wb_sel, fault};

    function automatic logic [18:0] pk(input logic mreq, input logic mwe, input logic asel,
                                       input logic irwe, input logic pcwe, input logic [1:0] pcsrc,
                                       input logic [3:0] alu, input logic [1:0] a, input logic [1:0] b,
                                       input logic rfwe, input logic [1:0] wb, input logic flt);
        return {mreq, mwe, asel, irwe, pcwe, pcsrc, alu, a, b, rfwe, wb, flt};
    endfunction

    function automatic logic [31:0] expIret(input int n);
`ifdef MC_CONTROL_PERF_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic [2:0] flg, input logic rdy);
        rst       = r;
        instr     = ins;
        flags     = flg;
        mem_ready = rdy;
        #1;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic fetchDecode(input logic [31:0] ins);
        applyStimulus(1'b0, ins, 3'b000, 1'b1);
        checkOutput("fetch", 32'(obsCtl), 32'(pk(1,0,0,1,1,2'd0,4'b0000,2'd1,2'd2,0,2'd0,0)));
        tick();
        applyStimulus(1'b0, ins, 3'b000, 1'b1);
        checkOutput("decode", 32'(obsCtl), 32'(pk(0,0,0,0,0,2'd0,4'b0000,2'd2,2'd1,0,2'd0,0)));
        tick();
    endtask

    task automatic stepCheck(input string tag, input logic [31:0] ins, input logic [2:0] flg,
                             input logic rdy, input logic [18:0] exp);
        applyStimulus(1'b0, ins, flg, rdy);
        checkOutput(tag, 32'(obsCtl), 32'(exp));
        tick();
    endtask

    task automatic runAlu(input string tag, input logic [31:0] ins, input logic [18:0] expExec);
        fetchDecode(ins);
        stepCheck(tag, ins, 3'b000, 1'b1, expExec);
        stepCheck("alu_wb", ins, 3'b000, 1'b1, pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,1,2'd0,0));
    endtask

    initial begin
        applyStimulus(1'b1, 32'd0, 3'b000, 1'b0);
        tick();
        checkOutput("reset_ctl", 32'(obsCtl), 32'(pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,0)));
        checkOutput("reset_instret", instret, 32'd0);
        applyStimulus(1'b1, I_ADD, 3'b000, 1'b1);
        checkOutput("reset_drops_req", 32'(obsCtl), 32'(pk(0,0,0,0,0,2'd0,4'b0000,2'd1,2'd2,0,2'd0,0)));
        tick();

        runAlu("add_exec", I_ADD, pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,0));
        checkOutput("instret_after_add", instret, expIret(1));
        runAlu("sub_exec", I_SUB, pk(0,0,0,0,0,2'd0,4'b0001,2'd0,2'd0,0,2'd0,0));
        runAlu("srai_exec", I_SRAI, pk(0,0,0,0,0,2'd0,4'b0111,2'd0,2'd1,0,2'd0,0));
        runAlu("addi_f7_exec", I_ADDIN, pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd1,0,2'd0,0));
        runAlu("lui_exec", I_LUI, pk(0,0,0,0,0,2'd0,4'b1010,2'd0,2'd1,0,2'd0,0));

        fetchDecode(I_BEQ);
        stepCheck("beq_taken", I_BEQ, 3'b100, 1'b1, pk(0,0,0,0,1,2'd1,4'b0001,2'd0,2'd0,0,2'd0,0));
        fetchDecode(I_BEQ);
        stepCheck("beq_not_taken", I_BEQ, 3'b000, 1'b1, pk(0,0,0,0,0,2'd0,4'b0001,2'd0,2'd0,0,2'd0,0));
        fetchDecode(I_BNE);
        stepCheck("bne_taken", I_BNE, 3'b000, 1'b1, pk(0,0,0,0,1,2'd1,4'b0001,2'd0,2'd0,0,2'd0,0));
        fetchDecode(I_BGEU);
        stepCheck("bgeu_not_taken", I_BGEU, 3'b001, 1'b1, pk(0,0,0,0,0,2'd0,4'b0001,2'd0,2'd0,0,2'd0,0));

        fetchDecode(I_LW);
        stepCheck("lw_exec", I_LW, 3'b000, 1'b1, pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd1,0,2'd0,0));
        for (int i = 0; i < 3; i++) begin
            stepCheck("lw_mem_wait", I_LW, 3'b000, 1'b0, pk(1,0,1,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,0));
        end
        stepCheck("lw_mem_done", I_LW, 3'b000, 1'b1, pk(1,0,1,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,0));
        stepCheck("lw_wb", I_LW, 3'b000, 1'b1, pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,1,2'd1,0));

        fetchDecode(I_SW);
        stepCheck("sw_exec", I_SW, 3'b000, 1'b1, pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd1,0,2'd0,0));
        stepCheck("sw_mem", I_SW, 3'b000, 1'b1, pk(1,1,1,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,0));

        fetchDecode(I_JAL);
        stepCheck("jal_exec", I_JAL, 3'b000, 1'b1, pk(0,0,0,0,1,2'd1,4'b0000,2'd0,2'd0,1,2'd2,0));
        fetchDecode(I_JALR);
        stepCheck("jalr_exec", I_JALR, 3'b000, 1'b1, pk(0,0,0,0,1,2'd2,4'b0000,2'd0,2'd1,1,2'd2,0));
        checkOutput("instret_total", instret, expIret(13));

        fetchDecode(I_ILL);
        for (int i = 0; i < 3; i++) begin
            stepCheck("illegal_fault", I_ILL, 3'b000, 1'b1, pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,1));
        end
        checkOutput("instret_no_retire_on_fault", instret, expIret(13));

        applyStimulus(1'b1, I_ILL, 3'b000, 1'b1);
        tick();
        checkOutput("rst_clears_fault", 32'(fault), 32'd0);
        checkOutput("rst_clears_instret", instret, 32'd0);
        checkOutput("rst_fetch_quiet", 32'(obsCtl), 32'(pk(0,0,0,0,0,2'd0,4'b0000,2'd1,2'd2,0,2'd0,0)));
        tick();

        for (int i = 0; i < 4; i++) begin
            stepCheck("stall_fetch", I_ADD, 3'b000, 1'b0, pk(1,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,0));
        end
        applyStimulus(1'b0, I_ADD, 3'b000, 1'b0);
        checkOutput("stall_timeout_fault", 32'(obsCtl), 32'(pk(0,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,1)));
        tick();
        applyStimulus(1'b1, I_ADD, 3'b000, 1'b0);
        tick();
        applyStimulus(1'b0, I_ADD, 3'b000, 1'b0);
        checkOutput("stall_rst_recover", 32'(obsCtl), 32'(pk(1,0,0,0,0,2'd0,4'b0000,2'd0,2'd0,0,2'd0,0)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
